mod_fetch_unit: RTL and testbench
=================================

# mod_fetch_unit

Instruction fetch stage for the single-issue MIPS core. It owns the program counter and drives the instruction-memory request/acknowledge handshake. It holds the fetched word in an instruction register and presents `opcode`/`funct` to the control unit. It consumes `jump`/`branch` from the control unit and `zero` from the ALU to select the next PC.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk`  in  1: sole clock; all state on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_req`  out  1: instruction-memory request; held high until acknowledged.
- `imem_addr`  out  32: byte address of the fetch; equals `pc` whenever `imem_req`=1.
- `imem_ack`  in  1: memory has valid data on `imem_rdata` this cycle.
- `imem_rdata`  in  32: instruction word.
- `stall`  in  1: hold the current instruction in EXEC (hazard or multi-cycle op).
- `jump`  in  1: from control unit.
- `branch`  in  1: from control unit.
- `zero`  in  1: ALU zero flag for the current instruction.
- `instr`  out  32: instruction register.
- `opcode`  out  6: `instr[31:26]`, to control unit.
- `funct`  out  6: `instr[5:0]`, to control unit.
- `pc`  out  32: address of the instruction in `instr`.
- `pc_plus4`  out  32: `pc + 4`, modulo 2^32.
- `instr_valid`  out  1: `instr` is valid and is being executed.
- `retired`  out  CNT_W: count of instructions that left EXEC.

## Operation
- FSM states: IDLE, FETCH, EXEC.
  - IDLE: entered on reset; moves to FETCH on the next edge unconditionally.
  - FETCH: `imem_req`=1 and `imem_addr`=`pc`.
    - `imem_ack`=1 at an edge: `instr` <= `imem_rdata`, `instr_valid` <= 1, go to EXEC.
    - Otherwise stay in FETCH with the address stable.
  - EXEC: `instr_valid`=1 and `imem_req`=0.
    - `stall`=1: hold all state.
    - `stall`=0: `pc` <= next_pc, `instr_valid` <= 0, `retired` += 1, go to FETCH.
- next_pc selection, priority order:
  1. `jump`=1: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  2. `branch`=1 and `zero`=1: `pc_plus4 + (sign_extend(instr[15:0]) << 2)`.
  3. Otherwise: `pc_plus4`.
- All PC arithmetic is 32-bit unsigned and wraps silently. 32'hFFFF_FFFC + 4 = 32'h0000_0000. Negative branch offsets wrap the same way.
- `imem_ack` outside FETCH is ignored; `instr` is not modified.
- `jump`, `branch` and `zero` are sampled only on the EXEC edge where `stall`=0.
- `retired` wraps from all-ones to 0.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state IDLE, `pc`=RESET_PC, `instr`=0 (so `opcode`=0, `funct`=0).
  - `instr_valid`=0, `imem_req`=0, `retired`=0.
  - `imem_addr`=RESET_PC, `pc_plus4`=RESET_PC+4.
- `opcode`, `funct`, `pc_plus4` and `imem_addr` are combinational from registers; they are glitch-free relative to the state.
- Zero-wait memory (`imem_ack` high in the first FETCH cycle): 2 cycles per instruction.
- Each memory wait cycle adds 1 cycle. Each stall cycle adds 1 cycle.
- First `imem_req` rises 1 cycle after `rst_n` deasserts (the IDLE cycle).
- If reset asserts mid-FETCH, `imem_req` drops immediately and the pending request is abandoned. Memory must tolerate this abandonment.
- `stall` and `imem_ack` never interact, since they are meaningful in different states.

## Structure
- Opcode constants (`j_opcode`, `beq_opcode`, etc.) and state encodings live in `instruction_defines.v`.
- Add `fetch_idle`, `fetch_fetch` and `fetch_exec` (2-bit encodings) to that file.
- One natural sub-module, `mod_next_pc`: purely combinational next-PC select.
  - Inputs: `pc_plus4`, `instr[25:0]`, `jump`, `branch`, `zero`.
  - Output: next_pc.
- The FSM, PC, IR and counter stay in the top module.

## Test plan
- Reset then zero-wait memory returning 32'h0000_0020 (add) at every address.
  - `imem_addr` sequence is 0, 4, 8, 12.
  - `instr_valid` toggles every cycle; `retired`=4 after 8 cycles.
- Memory holds `imem_ack` low 3 cycles at address 0.
  - `imem_req`/`imem_addr`=0 stay stable for 4 cycles.
  - `instr` updates only on the ack edge.
- beq at pc=32'h10 with imm=16'hFFFC, `branch`=1:
  - `zero`=1: next fetch address is 32'h04.
  - `zero`=0: next fetch address is 32'h14.
- j at pc=32'h1000_0008 with target field 26'h0000040 and `jump`=`branch`=`zero`=1: next fetch address is 32'h1000_0100, because jump has priority.
- `stall` high 5 cycles in EXEC: `pc`, `instr` and `retired` are unchanged and `instr_valid` stays 1. Afterwards pc advances by exactly 4.
- `pc`=32'hFFFF_FFFC with no branch: next fetch address is 32'h0.
- `rst_n` pulsed low mid-FETCH at pc=32'h8: `imem_req`=0 and `pc`=0 without waiting for a clock edge. Fetching resumes at 0.

Source files
------------

// File: rtl/mod_fetch_unit_pkg.sv
// Shared types for the fetch stage: FSM state encodings and the branch-offset helper.
package mod_fetch_unit_pkg;

  typedef enum logic [1:0] {
    fetch_idle  = 2'b00,
    fetch_fetch = 2'b01,
    fetch_exec  = 2'b10
  } fetch_state_t;

  // Word offset of a conditional branch: sign-extended immediate scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mod_fetch_unit_next_pc.sv
// Combinational next-PC select: jump over taken branch over sequential fall-through.
module mod_next_pc
  import mod_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_index,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr_index, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_offset(instr_index[15:0]);
    end
  end

endmodule

// File: rtl/mod_fetch_unit.sv
// Instruction fetch stage: owns the PC, the instruction register and the imem handshake.
module mod_fetch_unit
  import mod_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             jump,
  input  logic             branch,
  input  logic             zero,
  output logic [31:0]      instr,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             instr_valid,
  output logic [CNT_W-1:0] retired
);

  fetch_state_t state_q, state_d;
  logic [31:0]  next_pc;
  logic         fetch_done;
  logic         exec_done;

  assign fetch_done = (state_q == fetch_fetch) && imem_ack;
  assign exec_done  = (state_q == fetch_exec) && !stall;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];

  mod_next_pc u_next_pc (
    .pc_plus4    (pc_plus4),
    .instr_index (instr[25:0]),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .next_pc     (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= fetch_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      fetch_idle:  state_d = fetch_fetch;
      fetch_fetch: if (imem_ack) state_d = fetch_exec;
      fetch_exec:  if (!stall) state_d = fetch_fetch;
      default:     state_d = fetch_idle;
    endcase
  end

  always_comb begin
    imem_req = (state_q == fetch_fetch);
  end

  // The IR only loads on an acknowledged fetch, so stray acks in EXEC leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      retired     <= '0;
    end else begin
      if (fetch_done) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (exec_done) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
        retired     <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mod_fetch_unit.sv
// Directed bench for mod_fetch_unit; expected fetch addresses flow through a scoreboard queue.
module tb_mod_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic [31:0] retired;

  localparam logic [31:0] ADD_W      = 32'h0000_0020;
  localparam logic [31:0] BEQ_BACK_W = 32'h1022_FFFC;
  localparam logic [31:0] BEQ_WRAP_W = 32'h1000_FFFE;
  localparam logic [31:0] BEQ_FWD_W  = 32'h1000_7FFF;
  localparam logic [31:0] J_ZERO_W   = 32'h0800_0000;
  localparam logic [31:0] J_HI_W     = 32'h0800_0040;

  int          compared = 0;
  int          mismatched = 0;
  int          cycleCount = 0;
  int          c0;
  logic [31:0] expAddrQ[$];
  logic [31:0] expRetired;

  mod_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pops the expected fetch address, holds ack low for waitCycles, then returns word.
  task automatic fetchWord(input logic [31:0] word, input int waitCycles);
    logic [31:0] expAddr;
    logic [31:0] prevInstr;
    if (expAddrQ.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL scoreboard_empty: observed addr %h expected none", imem_addr);
      return;
    end
    expAddr   = expAddrQ.pop_front();
    prevInstr = instr;
    checkOutput("fetch_req", {31'd0, imem_req}, 32'd1);
    checkOutput("fetch_addr", imem_addr, expAddr);
    for (int i = 0; i < waitCycles; i++) begin
      imem_ack = 1'b0;
      tick();
      checkOutput("wait_req", {31'd0, imem_req}, 32'd1);
      checkOutput("wait_addr", imem_addr, expAddr);
      checkOutput("wait_instr", instr, prevInstr);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    checkOutput("ir_load", instr, word);
    checkOutput("valid_set", {31'd0, instr_valid}, 32'd1);
    checkOutput("req_drop", {31'd0, imem_req}, 32'd0);
    checkOutput("opcode", {26'd0, opcode}, {26'd0, word[31:26]});
    checkOutput("funct", {26'd0, funct}, {26'd0, word[5:0]});
    checkOutput("exec_pc", pc, expAddr);
  endtask

  // Stalls for stallCycles (with stray acks), then retires with the given controls.
  task automatic execStep(input logic j, input logic b, input logic z,
                          input int stallCycles, input logic [31:0] nextAddr);
    logic [31:0] pc0;
    logic [31:0] ir0;
    pc0 = pc;
    ir0 = instr;
    stall = 1'b1;
    for (int i = 0; i < stallCycles; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      tick();
      checkOutput("stall_pc", pc, pc0);
      checkOutput("stall_instr", instr, ir0);
      checkOutput("stall_retired", retired, expRetired);
      checkOutput("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_ack = 1'b0;
    stall    = 1'b0;
    jump     = j;
    branch   = b;
    zero     = z;
    expAddrQ.push_back(nextAddr);
    tick();
    jump   = 1'b0;
    branch = 1'b0;
    zero   = 1'b0;
    expRetired++;
    checkOutput("retired", retired, expRetired);
    checkOutput("valid_clear", {31'd0, instr_valid}, 32'd0);
    checkOutput("next_pc", pc, nextAddr);
  endtask

  task automatic applyStimulus;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    stall      = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    rst_n      = 1'b0;
    expRetired = 32'd0;
    #3;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_retired", retired, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_pc_plus4", pc_plus4, 32'h4);
    checkOutput("rst_opcode", {26'd0, opcode}, 32'd0);
    checkOutput("rst_funct", {26'd0, funct}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    expAddrQ.push_back(32'h0);

    // Two instructions, then reset lands in the middle of the fetch at 8.
    fetchWord(ADD_W, 0);
    execStep(1'b0, 1'b0, 1'b0, 0, 32'h4);
    fetchWord(ADD_W, 0);
    execStep(1'b0, 1'b0, 1'b0, 0, 32'h8);
    tick();
    checkOutput("pre_rst_addr", imem_addr, 32'h8);
    checkOutput("pre_rst_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_req", {31'd0, imem_req}, 32'd0);
    checkOutput("async_pc", pc, 32'h0);
    checkOutput("async_retired", retired, 32'd0);
    checkOutput("async_valid", {31'd0, instr_valid}, 32'd0);
    expAddrQ.delete();
    expRetired = 32'd0;
    tick();
    rst_n = 1'b1;
    checkOutput("idle2_req", {31'd0, imem_req}, 32'd0);
    tick();
    expAddrQ.push_back(32'h0);

    // Slow first fetch, then zero-wait instructions at 2 cycles each.
    fetchWord(ADD_W, 3);
    execStep(1'b0, 1'b0, 1'b0, 0, 32'h4);
    c0 = cycleCount;
    fetchWord(ADD_W, 0);
    execStep(1'b0, 1'b0, 1'b0, 0, 32'h8);
    fetchWord(ADD_W, 0);
    execStep(1'b0, 1'b0, 1'b0, 0, 32'hC);
    fetchWord(ADD_W, 0);
    execStep(1'b0, 1'b0, 1'b0, 0, 32'h10);
    checkOutput("zero_wait_cycles", 32'(cycleCount - c0), 32'd6);
    checkOutput("retired_four", retired, 32'd4);

    fetchWord(BEQ_BACK_W, 0);
    execStep(1'b0, 1'b1, 1'b1, 0, 32'h4);
    fetchWord(ADD_W, 0);
    execStep(1'b0, 1'b0, 1'b0, 0, 32'h8);
    fetchWord(ADD_W, 0);
    execStep(1'b0, 1'b0, 1'b0, 0, 32'hC);
    fetchWord(ADD_W, 0);
    execStep(1'b0, 1'b0, 1'b0, 0, 32'h10);
    fetchWord(BEQ_BACK_W, 0);
    execStep(1'b0, 1'b1, 1'b0, 0, 32'h14);
    fetchWord(ADD_W, 0);
    execStep(1'b0, 1'b0, 1'b0, 5, 32'h18);

    fetchWord(J_ZERO_W, 0);
    execStep(1'b1, 1'b0, 1'b0, 0, 32'h0);
    fetchWord(BEQ_WRAP_W, 0);
    execStep(1'b0, 1'b1, 1'b1, 0, 32'hFFFF_FFFC);
    fetchWord(ADD_W, 0);
    checkOutput("wrap_pc_plus4", pc_plus4, 32'h0);
    execStep(1'b0, 1'b0, 1'b0, 0, 32'h0);

    // Climb to 0x1000_0000 in +0x20000 branch hops to reach the jump test region.
    for (int i = 0; i < 2048; i++) begin
      fetchWord(BEQ_FWD_W, 0);
      execStep(1'b0, 1'b1, 1'b1, 0, 32'(i + 1) * 32'h0002_0000);
    end
    fetchWord(ADD_W, 0);
    execStep(1'b0, 1'b0, 1'b0, 0, 32'h1000_0004);
    fetchWord(ADD_W, 0);
    execStep(1'b0, 1'b0, 1'b0, 0, 32'h1000_0008);
    fetchWord(J_HI_W, 0);
    execStep(1'b1, 1'b1, 1'b1, 0, 32'h1000_0100);
    fetchWord(ADD_W, 1);
    execStep(1'b0, 1'b0, 1'b0, 0, 32'h1000_0104);
  endtask

  initial begin
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
